// File: rtl/layer_config_mem_pkg.sv
// Shared types and defaults for the layer config memory responder.
// Holds FSM state encoding, block-type codes and a saturating helper.
package layer_config_mem_pkg;

    localparam int unsigned CFG_MEM_DEPTH = 64;
    localparam int unsigned WORD_W        = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        BLK_CONV = 2'd0,
        BLK_POOL = 2'd1,
        BLK_FC   = 2'd2,
        BLK_ACT  = 2'd3
    } blk_type_e;

    function automatic logic [WORD_W-1:0] sat_inc(
        input logic [WORD_W-1:0] v
    );
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/layer_config_mem_array.sv
// Resettable config word array: one write port, one combinational read.
// Ports: clk_i, rst_ni, we_i/waddr_i/wdata_i write, raddr_i -> rdata_o.
module config_mem_array
    import layer_config_mem_pkg::*;
#(
    parameter  int unsigned DEPTH = CFG_MEM_DEPTH,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              we_i,
    input  logic [AW-1:0]     waddr_i,
    input  logic [WORD_W-1:0] wdata_i,
    input  logic [AW-1:0]     raddr_i,
    output logic [WORD_W-1:0] rdata_o
);

    logic [WORD_W-1:0] mem_q [DEPTH];
    logic [WORD_W-1:0] mem_d [DEPTH];

    always_comb begin
        mem_d = mem_q;
        if (we_i) begin
            mem_d[waddr_i] = wdata_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_q <= '{default: '0};
        end else begin
            mem_q <= mem_d;
        end
    end

    // Read sees the pre-edge contents, so a same-edge write is not visible.
    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/layer_config_mem.sv
// Config-memory responder for the inter-layer block scheduler read port.
// Ports: host write (cfg_write_*), scheduler read (config_mem_*),
// addr_err_o pulse with ready, read_count_o saturating response count.
module layer_config_mem
    import layer_config_mem_pkg::*;
#(
    parameter int unsigned DEPTH        = CFG_MEM_DEPTH,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        cfg_write_valid_i,
    input  logic [31:0] cfg_write_addr_i,
    input  logic [31:0] cfg_write_data_i,
    output logic        cfg_write_ready_o,
    input  logic [31:0] config_mem_addr_i,
    input  logic        config_mem_read_valid_i,
    output logic [31:0] config_mem_read_data_o,
    output logic        config_mem_read_ready_o,
    output logic        addr_err_o,
    output logic [31:0] read_count_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW =
        (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

    state_e      state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0] cap_q, cap_d;
    logic        cerr_q, cerr_d;
    logic [31:0] data_q, data_d;
    logic        ready_q, ready_d;
    logic        err_q, err_d;
    logic [31:0] count_q, count_d;
    logic        wr_rdy_q;

    logic        wr_in_range;
    logic        rd_in_range;
    logic        mem_we;
    logic [31:0] mem_rdata;

    // Range checks use the full index; only then are low bits used.
    assign wr_in_range = cfg_write_addr_i < 32'(DEPTH);
    assign rd_in_range = config_mem_addr_i < 32'(DEPTH);
    assign mem_we      = cfg_write_valid_i & wr_rdy_q & wr_in_range;

    config_mem_array #(
        .DEPTH (DEPTH)
    ) u_array (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .we_i    (mem_we),
        .waddr_i (cfg_write_addr_i[AW-1:0]),
        .wdata_i (cfg_write_data_i),
        .raddr_i (config_mem_addr_i[AW-1:0]),
        .rdata_o (mem_rdata)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cap_d   = cap_q;
        cerr_d  = cerr_q;
        data_d  = data_q;
        ready_d = 1'b0;
        err_d   = 1'b0;
        count_d = count_q;
        unique case (state_q)
            ST_IDLE: begin
                if (config_mem_read_valid_i) begin
                    cap_d   = rd_in_range ? mem_rdata : '0;
                    cerr_d  = ~rd_in_range;
                    cnt_d   = CW'(READ_LATENCY - 1);
                    state_d = (READ_LATENCY > 1) ? ST_WAIT : ST_RESP;
                end
            end
            ST_WAIT: begin
                if (cnt_q == CW'(1)) begin
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_RESP: begin
                // Outputs are registered, so the pulse appears one edge later.
                ready_d = 1'b1;
                err_d   = cerr_q;
                data_d  = cap_q;
                count_d = sat_inc(count_q);
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            cap_q    <= '0;
            cerr_q   <= 1'b0;
            data_q   <= '0;
            ready_q  <= 1'b0;
            err_q    <= 1'b0;
            count_q  <= '0;
            wr_rdy_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            cap_q    <= cap_d;
            cerr_q   <= cerr_d;
            data_q   <= data_d;
            ready_q  <= ready_d;
            err_q    <= err_d;
            count_q  <= count_d;
            wr_rdy_q <= 1'b1;
        end
    end

    assign cfg_write_ready_o       = wr_rdy_q;
    assign config_mem_read_data_o  = data_q;
    assign config_mem_read_ready_o = ready_q;
    assign addr_err_o              = err_q;
    assign read_count_o            = count_q;

endmodule

// File: tb/tb_layer_config_mem.sv
// Scoreboard bench for layer_config_mem at READ_LATENCY 1 and 3.
// Stimulus pushes expected responses; a negedge monitor pops and checks.
module tb_layer_config_mem;

    typedef struct {
        logic [31:0] data;
        logic        err;
        logic [31:0] cnt;
        int          cyc;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        wv   [2];
    logic [31:0] wa   [2];
    logic [31:0] wd   [2];
    logic        wrdy [2];
    logic [31:0] ra   [2];
    logic        rv   [2];
    logic [31:0] rdat [2];
    logic        rrdy [2];
    logic        aerr [2];
    logic [31:0] rcnt [2];

    exp_t q0[$];
    exp_t q1[$];
    int   issued [2];
    int   cyc;
    int   n_chk;
    int   n_pass;

    layer_config_mem #(.DEPTH(64), .READ_LATENCY(1)) u_dut1 (
        .clk_i                   (clk),
        .rst_ni                  (rst_n),
        .cfg_write_valid_i       (wv[0]),
        .cfg_write_addr_i        (wa[0]),
        .cfg_write_data_i        (wd[0]),
        .cfg_write_ready_o       (wrdy[0]),
        .config_mem_addr_i       (ra[0]),
        .config_mem_read_valid_i (rv[0]),
        .config_mem_read_data_o  (rdat[0]),
        .config_mem_read_ready_o (rrdy[0]),
        .addr_err_o              (aerr[0]),
        .read_count_o            (rcnt[0])
    );

    layer_config_mem #(.DEPTH(64), .READ_LATENCY(3)) u_dut3 (
        .clk_i                   (clk),
        .rst_ni                  (rst_n),
        .cfg_write_valid_i       (wv[1]),
        .cfg_write_addr_i        (wa[1]),
        .cfg_write_data_i        (wd[1]),
        .cfg_write_ready_o       (wrdy[1]),
        .config_mem_addr_i       (ra[1]),
        .config_mem_read_valid_i (rv[1]),
        .config_mem_read_data_o  (rdat[1]),
        .config_mem_read_ready_o (rrdy[1]),
        .addr_err_o              (aerr[1]),
        .read_count_o            (rcnt[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int lat(int d);
        return (d == 0) ? 1 : 3;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] req);
        n_chk++;
        if (act === req) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic mon(int d);
        exp_t e;
        int   sz;
        sz = (d == 0) ? q0.size() : q1.size();
        if (sz == 0) begin
            n_chk++;
            $display("FAIL spurious_ready dut%0d: got ready at cycle %0d, expected none",
                     d, cyc);
        end else begin
            if (d == 0) e = q0.pop_front();
            else        e = q1.pop_front();
            check($sformatf("rd_data_dut%0d", d), rdat[d], e.data);
            check($sformatf("addr_err_dut%0d", d), {31'd0, aerr[d]}, {31'd0, e.err});
            check($sformatf("read_count_dut%0d", d), rcnt[d], e.cnt);
            check($sformatf("ready_cycle_dut%0d", d), 32'(cyc), 32'(e.cyc));
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (rrdy[0]) mon(0);
            if (rrdy[1]) mon(1);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(int d, logic [31:0] ed, logic ee);
        exp_t e;
        issued[d]++;
        e.data = ed;
        e.err  = ee;
        e.cnt  = 32'(issued[d]);
        e.cyc  = cyc + 1 + lat(d);
        if (d == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    task automatic wr(int d, logic [31:0] a, logic [31:0] v);
        wv[d] = 1'b1;
        wa[d] = a;
        wd[d] = v;
        tick();
        wv[d] = 1'b0;
    endtask

    // Holds valid until just after the ready edge, like the scheduler.
    task automatic rd(int d, logic [31:0] a, logic [31:0] ed, logic ee);
        ra[d] = a;
        rv[d] = 1'b1;
        push(d, ed, ee);
        repeat (lat(d) + 1) tick();
    endtask

    task automatic check_idle_outputs(string tag);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("%s_data_dut%0d", tag, d), rdat[d], 32'd0);
            check($sformatf("%s_ready_dut%0d", tag, d), {31'd0, rrdy[d]}, 32'd0);
            check($sformatf("%s_err_dut%0d", tag, d), {31'd0, aerr[d]}, 32'd0);
            check($sformatf("%s_count_dut%0d", tag, d), rcnt[d], 32'd0);
            check($sformatf("%s_wrdy_dut%0d", tag, d), {31'd0, wrdy[d]}, 32'd0);
        end
    endtask

    initial begin
        n_chk  = 0;
        n_pass = 0;
        rst_n  = 1'b0;
        for (int d = 0; d < 2; d++) begin
            wv[d] = 1'b0; wa[d] = '0; wd[d] = '0;
            rv[d] = 1'b0; ra[d] = '0;
            issued[d] = 0;
        end
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        rst_n = 1'b1;
        tick();
        tick();
        check("wrdy_after_reset", {31'd0, wrdy[0]}, 32'd1);

        // Latency 1: loads, back-to-back reads, range errors.
        wr(0, 4, 222);
        wr(0, 0, 333);
        wr(0, 2, 444);
        wr(0, 63, 32'h0000_6363);
        wr(0, 68, 32'h0000_dead);
        rd(0, 4, 222, 1'b0);
        rd(0, 0, 333, 1'b0);
        rv[0] = 1'b0;
        tick();
        rd(0, 64, 0, 1'b1);
        rd(0, 32'h8000_0004, 0, 1'b1);
        rd(0, 63, 32'h0000_6363, 1'b0);
        rd(0, 4, 222, 1'b0);
        rv[0] = 1'b0;
        tick();

        // Same-edge write and read of word 2 returns the old word.
        wv[0] = 1'b1;
        wa[0] = 2;
        wd[0] = 999;
        rd(0, 2, 444, 1'b0);
        wv[0] = 1'b0;
        rd(0, 2, 999, 1'b0);
        rv[0] = 1'b0;
        tick();

        // Latency 3: exact pulse timing and data hold afterwards.
        wr(1, 1, 777);
        wr(1, 0, 555);
        rd(1, 1, 777, 1'b0);
        rv[1] = 1'b0;
        tick();
        check("hold_data_dut1", rdat[1], 32'd777);
        check("hold_ready_low_dut1", {31'd0, rrdy[1]}, 32'd0);

        // Valid dropped right after acceptance still yields one pulse.
        ra[1] = 0;
        rv[1] = 1'b1;
        push(1, 555, 1'b0);
        tick();
        rv[1] = 1'b0;
        repeat (8) tick();

        // Reset while waiting: no response, everything cleared.
        ra[1] = 1;
        rv[1] = 1'b1;
        tick();
        rv[1] = 1'b0;
        tick();
        rst_n = 1'b0;
        #2;
        check_idle_outputs("midreset");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        issued[0] = 0;
        issued[1] = 0;
        tick();
        tick();
        rd(1, 0, 0, 1'b0);
        rd(1, 1, 0, 1'b0);
        rv[1] = 1'b0;
        rd(0, 2, 0, 1'b0);
        rv[0] = 1'b0;
        repeat (6) tick();

        check("pending_dut0", 32'(q0.size()), 32'd0);
        check("pending_dut1", 32'(q1.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
